// File: rtl/adder_tree_sched.sv
// Round-robin issue scheduler for a shared pipelined adder_tree.
// Optional perf counters: define ADDER_TREE_SCHED_PERF_EN.
//
// Ports:
//   clock, reset_n   clock, async active-low reset
//   req_valid/ready  per-requester operand handshake (ready one-hot)
//   grant_idx/vld    operand mux select for this cycle
//   tree_ena         adder_tree clock_ena (global advance)
//   tree_result      adder_tree sum, passed to out_result
//   out_valid/ready  result handshake, out_id tags the requester
//   perf_*           issue/stall/bubble counters (perf build only)
module adder_tree_sched #(
  parameter int N            = 32,
  parameter int NUM_REQ      = 4,
  parameter int ID_WIDTH     = $clog2(NUM_REQ),
  parameter int RESULT_WIDTH = 38
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [ID_WIDTH-1:0]     grant_idx,
  output logic                    grant_vld,
  output logic                    tree_ena,
  input  logic [RESULT_WIDTH-1:0] tree_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ID_WIDTH-1:0]     out_id,
  output logic [RESULT_WIDTH-1:0] out_result
`ifdef ADDER_TREE_SCHED_PERF_EN
  ,
  output logic [31:0]             perf_issued,
  output logic [31:0]             perf_stall,
  output logic [31:0]             perf_bubble
`endif
);

  localparam int LAT = $clog2(N);

  logic [LAT-1:0]      vld;
  logic [ID_WIDTH-1:0] id [LAT];
  logic [ID_WIDTH-1:0] ptr;
  logic [ID_WIDTH-1:0] cand;
  logic                found;
  logic                advance;
  logic                issue;

  assign out_valid  = vld[LAT-1];
  assign out_id     = id[LAT-1];
  assign out_result = tree_result;
  assign advance    = !out_valid || out_ready;
  assign tree_ena   = advance;
  assign grant_vld  = |req_valid;
  // Gate with reset so no requester is consumed while held in reset.
  assign issue      = grant_vld && advance && reset_n;

  // Search starts just past the last granted requester and wraps.
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_WIDTH'((int'(ptr) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (issue)
      req_ready = NUM_REQ'(1) << grant_idx;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
      for (int k = 0; k < LAT; k++)
        id[k] <= '0;
      ptr <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      if (advance) begin
        vld[0] <= issue;
        id[0]  <= grant_idx;
        for (int k = 1; k < LAT; k++) begin
          vld[k] <= vld[k-1];
          id[k]  <= id[k-1];
        end
      end
      if (issue)
        ptr <= grant_idx;
    end
  end

`ifdef ADDER_TREE_SCHED_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_issued <= '0;
      perf_stall  <= '0;
      perf_bubble <= '0;
    end else begin
      if (issue && perf_issued != '1)
        perf_issued <= perf_issued + 32'd1;
      if (!advance && perf_stall != '1)
        perf_stall <= perf_stall + 32'd1;
      if (advance && !grant_vld && perf_bubble != '1)
        perf_bubble <= perf_bubble + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adder_tree_sched.sv
// Directed bench for adder_tree_sched (N=32 -> LAT=5, NUM_REQ=4).
// Inputs change 1ns after the rising edge, outputs are checked 1ns later.
module tb_adder_tree_sched;

  logic        clock;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [1:0]  grant_idx;
  logic        grant_vld;
  logic        tree_ena;
  logic [37:0] tree_result;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_id;
  logic [37:0] out_result;
`ifdef ADDER_TREE_SCHED_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;
  logic [31:0] perf_bubble;
`endif

  int errs;
  int checks;

  adder_tree_sched dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .grant_idx   (grant_idx),
    .grant_vld   (grant_vld),
    .tree_ena    (tree_ena),
    .tree_result (tree_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_id      (out_id),
    .out_result  (out_result)
`ifdef ADDER_TREE_SCHED_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall),
    .perf_bubble (perf_bubble)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: bench exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench at the start of cycle 0 with reset released.
  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = 4'hF;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    step();
    step();
    reset_n   = 1'b1;
    req_valid = 4'h0;
  endtask

  initial begin
    int g;
    int eid;
    logic stall;
    errs        = 0;
    checks      = 0;
    tree_result = 38'h2A_1234_5678;
    reset_n     = 1'b0;
    req_valid   = 4'h0;
    out_ready   = 1'b1;

    // Single issue
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req_valid = (c == 0) ? 4'b0001 : 4'b0000;
      #1;
      if (c == 0) begin
        chk("single_ready", req_ready, 4'b0001);
        chk("single_grant", grant_idx, 0);
      end
      chk($sformatf("single_ov_c%0d", c), out_valid, c == 5);
      if (c == 5) begin
        chk("single_id", out_id, 0);
        chk("single_res", out_result, 38'h2A_1234_5678);
      end
      step();
    end

    // Round-robin
    do_reset();
    for (int c = 0; c < 10; c++) begin
      req_valid = 4'hF;
      #1;
      chk($sformatf("rr_grant_c%0d", c), grant_idx, c % 4);
      chk($sformatf("rr_ready_c%0d", c), req_ready, 4'b1 << (c % 4));
      chk($sformatf("rr_ov_c%0d", c), out_valid, c >= 5);
      if (c >= 5)
        chk($sformatf("rr_id_c%0d", c), out_id, (c - 5) % 4);
      step();
    end

    // Backpressure in cycles 6-8
    do_reset();
    for (int c = 0; c < 20; c++) begin
      stall     = (c >= 6 && c <= 8);
      req_valid = 4'hF;
      out_ready = !stall;
      #1;
      if (c < 6)       g = c % 4;
      else if (c <= 8) g = 2;
      else             g = (c - 7) % 4;
      chk($sformatf("bp_grant_c%0d", c), grant_idx, g);
      chk($sformatf("bp_gvld_c%0d", c), grant_vld, 1);
      chk($sformatf("bp_ready_c%0d", c), req_ready,
          stall ? 4'b0 : (4'b1 << g));
      chk($sformatf("bp_ena_c%0d", c), tree_ena, !stall);
      chk($sformatf("bp_ov_c%0d", c), out_valid, c >= 5);
      if (c >= 5) begin
        if (c == 5)      eid = 0;
        else if (c <= 9) eid = 1;
        else             eid = (c - 8) % 4;
        chk($sformatf("bp_id_c%0d", c), out_id, eid);
      end
      step();
    end
`ifdef ADDER_TREE_SCHED_PERF_EN
    chk("perf_stall", perf_stall, 3);
    chk("perf_issued", perf_issued, 17);
    chk("perf_bubble", perf_bubble, 0);
`endif
    out_ready = 1'b1;

    // Mid-run reset with 3 sums in flight
    do_reset();
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'hF;
      #1;
      chk($sformatf("mr_grant_c%0d", c), grant_idx, c);
      step();
    end
    reset_n = 1'b0;
    #1;
    chk("mr_ov_in_rst", out_valid, 0);
    chk("mr_rdy_in_rst", req_ready, 0);
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("mr_grant2_c%0d", c), grant_idx, c % 4);
      chk($sformatf("mr_ov_c%0d", c), out_valid, c == 5);
      step();
    end

    // Sparse plus wrap
    do_reset();
    for (int c = 0; c < 9; c++) begin
      case (c)
        0:       req_valid = 4'b1000;
        2:       req_valid = 4'b0001;
        default: req_valid = 4'b0000;
      endcase
      #1;
      if (c == 0) chk("sp_grant3", grant_idx, 3);
      if (c == 1) chk("sp_bubble_gvld", grant_vld, 0);
      if (c == 2) chk("sp_grant0", grant_idx, 0);
      chk($sformatf("sp_ov_c%0d", c), out_valid, c == 5 || c == 7);
      if (c == 5) chk("sp_id5", out_id, 3);
      if (c == 7) chk("sp_id7", out_id, 0);
      step();
    end

    // Single active requester
    do_reset();
    for (int c = 0; c < 4; c++) begin
      req_valid = 4'b0100;
      #1;
      chk($sformatf("one_grant_c%0d", c), grant_idx, 2);
      chk($sformatf("one_ready_c%0d", c), req_ready, 4'b0100);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
